// File: rtl/approx_mul_pkg.sv
// Shared encodings for the quadrant approximate multiplier: approximation
// levels and the bit offsets of each quadrant's field inside the mode byte.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    APX_EXACT = 2'd0,
    APX_T1    = 2'd1,
    APX_T2    = 2'd2,
    APX_T3    = 2'd3
  } apx_level_e;

  localparam int QHH = 6;
  localparam int QHL = 4;
  localparam int QLH = 2;
  localparam int QLL = 0;

  // Extract one quadrant's 2-bit level from the mode byte.
  function automatic logic [1:0] mode_field(input logic [7:0] mode, input int off);
    return mode[off +: 2];
  endfunction

endpackage

// File: rtl/approx_quad_mul.sv
// Combinational HALF_W x HALF_W quadrant multiplier; level k clears the k LSBs
// of both operands before an exact multiply.
module approx_quad_mul
  import approx_mul_pkg::*;
#(
  parameter int HALF_W = 4
) (
  input  logic [HALF_W-1:0]   i_x,
  input  logic [HALF_W-1:0]   i_y,
  input  logic [1:0]          i_lvl,
  output logic [2*HALF_W-1:0] o_q
);

  localparam int QW = 2 * HALF_W;

  logic [HALF_W-1:0] w_mask;

  // Operand truncation mask; shifting past HALF_W naturally yields an all-zero mask.
  always_comb begin
    w_mask = {HALF_W{1'b1}};
    case (apx_level_e'(i_lvl))
      APX_EXACT: w_mask = {HALF_W{1'b1}};
      APX_T1:    w_mask = {HALF_W{1'b1}} << 32'd1;
      APX_T2:    w_mask = {HALF_W{1'b1}} << 32'd2;
      APX_T3:    w_mask = {HALF_W{1'b1}} << 32'd3;
      default:   w_mask = {HALF_W{1'b1}};
    endcase
  end

  assign o_q = QW'(i_x & w_mask) * QW'(i_y & w_mask);

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage pipelined quadrant approximate multiplier behind valid/ready.
// Define APPROX_MUL_ERRSTAT_EN to add the exact reference and error statistics.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int HALF_W = 4,
  parameter int ERR_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] a,
  input  logic [2*HALF_W-1:0] b,
  input  logic [7:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*HALF_W-1:0] prod,
  input  logic                stat_clr,
  output logic [ERR_W-1:0]    err_acc,
  output logic [ERR_W-1:0]    sample_cnt
);

  localparam int OW = 2 * HALF_W;
  localparam int PW = 4 * HALF_W;

  logic [HALF_W-1:0] w_ah, w_al, w_bh, w_bl;
  logic [OW-1:0]     w_hh, w_hl, w_lh, w_ll;
  logic [PW-1:0]     w_sum;
  logic              w_s1_load, w_s2_load;

  logic              r_s1_valid, r_s2_valid;
  logic [OW-1:0]     r_hh, r_hl, r_lh, r_ll;
  logic [PW-1:0]     r_prod;

  assign w_ah = a[OW-1:HALF_W];
  assign w_al = a[HALF_W-1:0];
  assign w_bh = b[OW-1:HALF_W];
  assign w_bl = b[HALF_W-1:0];

  approx_quad_mul #(.HALF_W(HALF_W)) u_hh (.i_x(w_ah), .i_y(w_bh), .i_lvl(mode_field(mode, QHH)), .o_q(w_hh));
  approx_quad_mul #(.HALF_W(HALF_W)) u_hl (.i_x(w_ah), .i_y(w_bl), .i_lvl(mode_field(mode, QHL)), .o_q(w_hl));
  approx_quad_mul #(.HALF_W(HALF_W)) u_lh (.i_x(w_al), .i_y(w_bh), .i_lvl(mode_field(mode, QLH)), .o_q(w_lh));
  approx_quad_mul #(.HALF_W(HALF_W)) u_ll (.i_x(w_al), .i_y(w_bl), .i_lvl(mode_field(mode, QLL)), .o_q(w_ll));

  // in_ready depends only on stage state and out_ready, never on in_valid.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  assign w_sum = (PW'(r_hh) << (2 * HALF_W)) + ((PW'(r_hl) + PW'(r_lh)) << HALF_W) + PW'(r_ll);

  // Stage 1: register the four quadrant products on the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_hh       <= {OW{1'b0}};
      r_hl       <= {OW{1'b0}};
      r_lh       <= {OW{1'b0}};
      r_ll       <= {OW{1'b0}};
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_hh <= w_hh;
        r_hl <= w_hl;
        r_lh <= w_lh;
        r_ll <= w_ll;
      end
    end
  end

  // Stage 2: register the shifted quadrant sum; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_prod     <= {PW{1'b0}};
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_prod <= w_sum;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign prod      = r_prod;

`ifdef APPROX_MUL_ERRSTAT_EN
  localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;

  logic [PW-1:0]    w_exact, w_diff;
  logic [SW-1:0]    w_err_sum;
  logic             w_out_hs;
  logic [PW-1:0]    r_s1_exact, r_s2_exact;
  logic [ERR_W-1:0] r_err_acc, r_sample_cnt;

  assign w_exact   = PW'(a) * PW'(b);
  assign w_out_hs  = r_s2_valid && out_ready;
  assign w_diff    = (r_s2_exact >= r_prod) ? (r_s2_exact - r_prod) : (r_prod - r_s2_exact);
  assign w_err_sum = SW'(r_err_acc) + SW'(w_diff);

  // Exact reference product travels alongside the quadrants so it aligns with prod.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_exact <= {PW{1'b0}};
      r_s2_exact <= {PW{1'b0}};
    end else begin
      if (w_s1_load && in_valid) begin
        r_s1_exact <= w_exact;
      end
      if (w_s2_load && r_s1_valid) begin
        r_s2_exact <= r_s1_exact;
      end
    end
  end

  // Saturating statistics; a coincident clear wins and drops that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_acc    <= {ERR_W{1'b0}};
      r_sample_cnt <= {ERR_W{1'b0}};
    end else if (stat_clr) begin
      r_err_acc    <= {ERR_W{1'b0}};
      r_sample_cnt <= {ERR_W{1'b0}};
    end else if (w_out_hs) begin
      if (w_err_sum > SW'({ERR_W{1'b1}})) begin
        r_err_acc <= {ERR_W{1'b1}};
      end else begin
        r_err_acc <= w_err_sum[ERR_W-1:0];
      end
      if (r_sample_cnt != {ERR_W{1'b1}}) begin
        r_sample_cnt <= r_sample_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign err_acc    = r_err_acc;
  assign sample_cnt = r_sample_cnt;
`else
  logic w_unused_stat_clr;

  assign w_unused_stat_clr = stat_clr;
  assign err_acc           = {ERR_W{1'b0}};
  assign sample_cnt        = {ERR_W{1'b0}};
`endif

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined successor to the fixed 8x8 quadrant approximate multiplier. It splits two 2·HALF_W-bit unsigned operands into high and low halves and forms four HALF_W×HALF_W quadrant products (HH, HL, LH, LL), each at a per-transaction selectable approximation level. It then shifts and adds the quadrants into the full 4·HALF_W-bit product. It sits in the datapath behind a valid/ready stream and optionally tracks accumulated error against an exact product.

## Interface
Parameters:
- HALF_W, 4: quadrant operand width; operand width is 2·HALF_W, product width is 4·HALF_W.
- ERR_W, 32: width of error accumulator and sample counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/mode valid.
- in_ready  out  1  block can accept.
- a, b  in  2·HALF_W  unsigned operands.
- mode  in  8  approximation levels, 2 bits per quadrant: [7:6] HH, [5:4] HL, [3:2] LH, [1:0] LL.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts.
- prod  out  4·HALF_W  approximate product.
- stat_clr  in  1  synchronous clear of statistics.
- err_acc  out  ERR_W  saturating sum of |exact − approx|.
- sample_cnt  out  ERR_W  saturating count of products delivered.

## Operation
- Levels: 0 exact; level k in 1..3 clears the k LSBs of both quadrant operands, then multiplies exactly: q = ((x>>k)<<k)·((y>>k)<<k). Level k with k ≥ HALF_W yields 0.
- Quadrants: HH = ah·bh, HL = ah·bl, LH = al·bh, LL = al·bl.
- Sum: prod = (HH << 2·HALF_W) + ((HL + LH) << HALF_W) + LL. The sum is computed at full 4·HALF_W width; no overflow is possible.
- mode, a and b are captured together on the input handshake (in_valid && in_ready). Each transaction uses its own mode.
- Stage S1 registers the four quadrant products, plus the exact product when statistics are enabled. Stage S2 registers prod.
- Stage advance rules:
  - S2 loads when it is empty or out_ready is high.
  - S1 loads when it is empty or S2 loads.
  - in_ready = !s1_valid || s2 loads.
  - No combinational path from in_valid to in_ready.
- out_valid holds and prod stays stable while out_ready is low.
- Reset values: out_valid 0, in_ready 1 after reset release, prod 0, err_acc 0, sample_cnt 0, all stage valids 0. Reset mid-operation discards in-flight data with no output.

## Timing
- Latency 2: a transaction accepted at edge t gives out_valid at t+2 when there are no stalls.
- Throughput is 1 per cycle with out_ready held high.
- With out_ready low, at most 2 transactions are held. in_ready drops in the cycle after S1 and S2 are both full.
- Statistics update on the output handshake edge (out_valid && out_ready):
  - err_acc += |exact − prod|
  - sample_cnt += 1
  - Both saturate at all-ones.
- stat_clr has priority: if it coincides with a handshake, both outputs go to 0 and that sample is discarded.

## Configuration
- APPROX_MUL_ERRSTAT_EN defined:
  - an exact 2·HALF_W multiplier is instantiated;
  - the exact product is carried through S1 alongside the quadrants;
  - err_acc and sample_cnt are live.
- Undefined:
  - no exact multiplier and no statistics registers;
  - err_acc and sample_cnt are tied to 0 and stat_clr is ignored;
  - ports remain present, so the interface is identical.

## Structure
- Shared package approx_mul_pkg holds:
  - level encoding: APX_EXACT=0, APX_T1=1, APX_T2=2, APX_T3=3;
  - quadrant mode field offsets: QHH=6, QHL=4, QLH=2, QLL=0.
- One sub-module, approx_quad_mul: combinational HALF_W×HALF_W multiplier with a 2-bit level input, instantiated four times.
- Pipeline registers, handshake and statistics live in approx_mul_pipe.

## Test plan
- HALF_W=4, a=0xFF, b=0xFF, mode=0x00 → prod=0xFE01 two cycles after accept; with stats, err_acc=0 and sample_cnt=1.
- a=0xFF, b=0xFF, mode=0x15 (HH exact, others level 1) → prod=0xFA44; err_acc increments by 957.
- a=0xFF, b=0xFF, mode=0xFF → prod=0x4840. Back-to-back with mode=0x00 → next prod=0xFE01, showing per-transaction mode.
- Stream 4 transactions while holding out_ready low for 3 cycles:
  - in_ready falls after 2 are held;
  - prod stays stable;
  - no loss or reorder after release.
- Assert rst_n low with both stages full → out_valid=0 immediately, err_acc=0, in_ready=1 after release; no stale output.
- stat_clr coincident with an output handshake → err_acc=0 and sample_cnt=0 next cycle. Force near all-ones via long run at ERR_W=8 → saturates at 0xFF.
